// File: rtl/alarm_unit.sv
// Alarm stage behind the min:sec counter: synchronises live time and buttons,
// holds a settable alarm time, and rings a gated buzzer on entry into a match.
module alarm_unit #(
  parameter int CLK_HZ   = 50000000,
  parameter int TONE_HZ  = 1000,
  parameter int RING_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic       i_set_en,
  input  logic       i_pos,
  input  logic       i_inc,
  input  logic       i_arm,
  input  logic       i_stop,
  output logic [5:0] o_alarm_sec,
  output logic [5:0] o_alarm_min,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_buzz
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int TH = CLK_HZ / (2 * TONE_HZ);
  localparam int TW = $clog2(TH + 1);
  localparam logic [PW-1:0] P_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
  localparam logic [RW-1:0] RS_MAX = RW'(RING_SEC - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;

  state_t        state, state_nx;
  logic [5:0]    sec_s1, sec_s2, min_s1, min_s2;
  logic [2:0]    btn_s1, btn_s2, btn_q;
  logic [2:0]    pulse;
  logic          inc_p, arm_p, stop_p;
  logic          match_r, match_q, trigger;
  logic [PW-1:0] p, p_nx;
  logic [RW-1:0] rs, rs_nx;
  logic [TW-1:0] tc, tc_nx;
  logic          tone, tone_nx;
  logic          hold, timeout, buzz_nx;

  // Live time changes rarely, so per-bit skew through the 2-flop sync is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_s1  <= '0;
      sec_s2  <= '0;
      min_s1  <= '0;
      min_s2  <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_q   <= '0;
      match_r <= 1'b0;
      match_q <= 1'b0;
    end else begin
      sec_s1  <= i_sec;
      sec_s2  <= sec_s1;
      min_s1  <= i_min;
      min_s2  <= min_s1;
      btn_s1  <= {i_stop, i_arm, i_inc};
      btn_s2  <= btn_s1;
      btn_q   <= btn_s2;
      match_r <= (sec_s2 == o_alarm_sec) && (min_s2 == o_alarm_min);
      match_q <= match_r;
    end
  end

  assign pulse   = btn_s2 & ~btn_q;
  assign inc_p   = pulse[0];
  assign arm_p   = pulse[1];
  assign stop_p  = pulse[2];
  assign trigger = match_r & ~match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alarm_sec <= '0;
      o_alarm_min <= '0;
    end else if (i_set_en && inc_p) begin
      if (i_pos)
        o_alarm_min <= (o_alarm_min == 6'd59) ? 6'd0 : o_alarm_min + 6'd1;
      else
        o_alarm_sec <= (o_alarm_sec == 6'd59) ? 6'd0 : o_alarm_sec + 6'd1;
    end
  end

  assign timeout = (state == RINGING) && (p == P_MAX) && (rs == RS_MAX);

  // Event priority: arm > stop > set_en > timeout > trigger.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm_p) state_nx = ARMED;
      ARMED: begin
        if (arm_p)                     state_nx = IDLE;
        else if (trigger && !i_set_en) state_nx = RINGING;
      end
      RINGING: begin
        if (arm_p)                             state_nx = IDLE;
        else if (stop_p || i_set_en || timeout) state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Timers advance only while staying in RINGING, so entry and exit both clear them.
  always_comb begin
    hold    = (state == RINGING) && (state_nx == RINGING);
    p_nx    = '0;
    rs_nx   = '0;
    tc_nx   = '0;
    tone_nx = 1'b0;
    if (hold) begin
      p_nx    = (p == P_MAX) ? '0 : p + 1'b1;
      rs_nx   = (p == P_MAX) ? rs + 1'b1 : rs;
      tc_nx   = (tc == T_MAX) ? '0 : tc + 1'b1;
      tone_nx = (tc == T_MAX) ? ~tone : tone;
    end
    buzz_nx = (state_nx == RINGING) && (p_nx < P_HALF) && tone_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_armed   <= 1'b0;
      o_ringing <= 1'b0;
      o_buzz    <= 1'b0;
      p         <= '0;
      rs        <= '0;
      tc        <= '0;
      tone      <= 1'b0;
    end else begin
      state     <= state_nx;
      o_armed   <= (state_nx != IDLE);
      o_ringing <= (state_nx == RINGING);
      o_buzz    <= buzz_nx;
      p         <= p_nx;
      rs        <= rs_nx;
      tc        <= tc_nx;
      tone      <= tone_nx;
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit with a scaled-down clock: setup vectors, ring timing,
// stop/disarm/setup interactions, randomized alarm trials and async reset.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_sec, i_min;
  logic       i_set_en, i_pos, i_inc, i_arm, i_stop;
  logic [5:0] o_alarm_sec, o_alarm_min;
  logic       o_armed, o_ringing, o_buzz;

  int n_checks = 0;
  int n_errors = 0;

  alarm_unit #(.CLK_HZ(1000), .TONE_HZ(100), .RING_SEC(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_sec(i_sec), .i_min(i_min),
    .i_set_en(i_set_en), .i_pos(i_pos), .i_inc(i_inc), .i_arm(i_arm),
    .i_stop(i_stop), .o_alarm_sec(o_alarm_sec), .o_alarm_min(o_alarm_min),
    .o_armed(o_armed), .o_ringing(o_ringing), .o_buzz(o_buzz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic set_en;
    logic pos;
    int   n;
    int   exp_sec;
    int   exp_min;
  } setup_vec_t;

  setup_vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      i_inc = 1'b1;
      tick(3);
      i_inc = 1'b0;
      tick(3);
    end
  endtask

  task automatic press(input logic arm, input logic stop);
    i_arm  = arm;
    i_stop = stop;
    tick(3);
    i_arm  = 1'b0;
    i_stop = 1'b0;
    tick(3);
  endtask

  // Drop the match for a while, then re-enter it: four edges until ringing.
  task automatic retrigger(input int sec, input int min);
    i_min = 6'(min);
    i_sec = 6'((sec + 1) % 60);
    tick(6);
    i_sec = 6'(sec);
    tick(4);
  endtask

  initial begin
    int k, bad, first_bad, exp_buzz, m_sec, m_min, n, eq;
    logic pos;

    rst_n = 1'b0;
    i_sec = '0; i_min = '0;
    i_set_en = 1'b0; i_pos = 1'b0; i_inc = 1'b0; i_arm = 1'b0; i_stop = 1'b0;
    tick(3);
    check("reset_alarm_sec", o_alarm_sec, 0);
    check("reset_alarm_min", o_alarm_min, 0);
    check("reset_armed", o_armed, 0);
    check("reset_ringing", o_ringing, 0);
    check("reset_buzz", o_buzz, 0);
    rst_n = 1'b1;
    tick(3);

    // Setup vectors; rows with set_en=0 must leave the fields untouched.
    vecs[0] = '{1'b1, 1'b1, 5,  0, 5};
    vecs[1] = '{1'b1, 1'b0, 62, 2, 5};
    vecs[2] = '{1'b0, 1'b0, 3,  2, 5};
    vecs[3] = '{1'b0, 1'b1, 2,  2, 5};
    for (int i = 0; i < 4; i++) begin
      i_set_en = vecs[i].set_en;
      i_pos    = vecs[i].pos;
      press_inc(vecs[i].n);
      i_set_en = 1'b0;
      tick(1);
      check($sformatf("setup_sec[%0d]", i), o_alarm_sec, vecs[i].exp_sec);
      check($sformatf("setup_min[%0d]", i), o_alarm_min, vecs[i].exp_min);
    end
    check("idle_not_armed", o_armed, 0);

    // Arm, then exact 4-edge ring latency.
    press(1'b1, 1'b0);
    check("arm_armed", o_armed, 1);
    i_min = 6'd5;
    i_sec = 6'd2;
    tick(3);
    check("ring_latency_pre", o_ringing, 0);
    tick(1);
    check("ring_latency", o_ringing, 1);

    // k counts cycles since entry; beep for the first half of each second.
    k = 0; bad = 0; first_bad = -1;
    while (o_ringing === 1'b1 && k < 5000) begin
      exp_buzz = ((k % 1000) < 500 && ((k / 5) % 2) == 1) ? 1 : 0;
      if (o_buzz !== exp_buzz[0]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      k++;
      tick(1);
    end
    check("ring_length", k, 3000);
    check("buzz_pattern_errors", bad, 0);
    if (bad != 0) $display("  first buzz error at ring cycle %0d", first_bad);
    check("timeout_armed", o_armed, 1);
    check("timeout_buzz", o_buzz, 0);
    tick(50);
    check("no_rering_held_match", o_ringing, 0);
    retrigger(2, 5);
    check("rering_after_drop", o_ringing, 1);

    // Stop pulse: 3 edges after the rise, back to ARMED with buzzer off.
    tick(7);
    i_stop = 1'b1;
    tick(2);
    check("stop_latency_pre", o_ringing, 1);
    tick(1);
    check("stop_ringing", o_ringing, 0);
    check("stop_buzz", o_buzz, 0);
    check("stop_armed", o_armed, 1);
    i_stop = 1'b0;
    tick(3);

    retrigger(2, 5);
    check("retrig_before_disarm", o_ringing, 1);
    press(1'b1, 1'b0);
    check("disarm_armed", o_armed, 0);
    check("disarm_ringing", o_ringing, 0);

    press(1'b1, 1'b0);
    retrigger(2, 5);
    check("retrig_before_both", o_ringing, 1);
    press(1'b1, 1'b1);
    check("arm_beats_stop_armed", o_armed, 0);
    check("arm_beats_stop_ringing", o_ringing, 0);

    // Setup mode suppresses triggers and forces RINGING back to ARMED.
    press(1'b1, 1'b0);
    i_sec = 6'd3;
    tick(6);
    i_set_en = 1'b1;
    i_sec = 6'd2;
    tick(8);
    check("setup_blocks_ring", o_ringing, 0);
    i_set_en = 1'b0;
    tick(8);
    check("setup_trigger_consumed", o_ringing, 0);
    retrigger(2, 5);
    check("ring_before_setup", o_ringing, 1);
    i_set_en = 1'b1;
    tick(1);
    check("setup_exits_ring", o_ringing, 0);
    check("setup_exit_armed", o_armed, 1);
    i_set_en = 1'b0;
    tick(2);

    // Randomized trials against a mod-60 model of the alarm fields.
    m_sec = 2;
    m_min = 5;
    for (int t = 0; t < 6; t++) begin
      pos = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 65);
      i_set_en = 1'b1;
      i_pos = pos;
      press_inc(n);
      i_set_en = 1'b0;
      tick(2);
      if (pos) m_min = (m_min + n) % 60;
      else     m_sec = (m_sec + n) % 60;
      check($sformatf("rand_sec[%0d]", t), o_alarm_sec, m_sec);
      check($sformatf("rand_min[%0d]", t), o_alarm_min, m_min);
      i_min = 6'(m_min);
      i_sec = 6'((m_sec + 1) % 60);
      tick(6);
      eq = $urandom_range(0, 1);
      if (eq == 1) begin
        i_sec = 6'(m_sec);
        i_min = 6'(m_min);
      end else begin
        i_sec = 6'($urandom_range(0, 59));
        i_min = 6'($urandom_range(0, 59));
      end
      tick(6);
      check($sformatf("rand_ring[%0d]", t), o_ringing,
            (int'(i_sec) == m_sec && int'(i_min) == m_min) ? 1 : 0);
      if (o_ringing === 1'b1) begin
        press(1'b0, 1'b1);
        check($sformatf("rand_stop[%0d]", t), o_ringing, 0);
      end
    end

    // Asynchronous reset between edges while the buzzer is sounding.
    retrigger(m_sec, m_min);
    check("pre_reset_ringing", o_ringing, 1);
    tick(6);
    check("pre_reset_buzz", o_buzz, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ringing", o_ringing, 0);
    check("async_buzz", o_buzz, 0);
    check("async_armed", o_armed, 0);
    check("async_alarm_sec", o_alarm_sec, 0);
    check("async_alarm_min", o_alarm_min, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Alarm stage that sits directly downstream of the min:sec counter.
- Samples the live minute/second values, holds a user-settable alarm time, and compares the two.
- On a match it rings a gated buzzer for a fixed duration, until stopped, or until disarmed.
- All logic runs on the 50 MHz system clock. Button inputs arrive already debounced.

Parameters:
- CLK_HZ, 50000000, system clock frequency; also the length of one ring second in clk cycles.
- TONE_HZ, 1000, buzzer square-wave frequency.
- RING_SEC, 30, ring duration in seconds before auto-stop.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- i_sec  input  6  live seconds 0..59, from another clock domain
- i_min  input  6  live minutes 0..59, from another clock domain
- i_set_en  input  1  level; 1 = alarm-time setup mode
- i_pos  input  1  setup field select; 0 = seconds, 1 = minutes
- i_inc  input  1  debounced level button; each rising edge increments the selected field
- i_arm  input  1  debounced level button; each rising edge toggles armed/disarmed
- i_stop  input  1  debounced level button; a rising edge silences ringing
- o_alarm_sec  output  6  alarm seconds setting
- o_alarm_min  output  6  alarm minutes setting
- o_armed  output  1  1 in ARMED or RINGING
- o_ringing  output  1  1 in RINGING
- o_buzz  output  1  buzzer drive

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs reset to 0; state resets to IDLE.
  - All sync flops, edge flops, prescalers and timers reset to 0.
  - Reset mid-ring drops o_buzz and o_ringing immediately.
- Input synchronisation:
  - i_sec and i_min each pass through a 2-flop synchroniser.
  - Upstream values change at most once per 1000 clk cycles, so multi-bit skew is tolerated.
  - i_inc, i_arm and i_stop each pass through a 2-flop synchroniser plus an edge flop.
  - A rise produces a 1-cycle pulse, 3 clk edges after the input rises.
- Setup:
  - Active only while i_set_en=1. An inc pulse adds 1 to the field chosen by i_pos.
  - 59 wraps to 0. There is no carry into the other field.
  - Out-of-range values cannot occur, because the increment logic wraps at 59.
- Match detection:
  - match = (synced sec == o_alarm_sec) AND (synced min == o_alarm_min).
  - match is registered, and a trigger is match AND NOT match_q.
  - A trigger therefore fires once per entry into the match condition, not once per cycle.
- State machine (IDLE, ARMED, RINGING):
  - IDLE: arm pulse -> ARMED.
  - ARMED:
    - arm pulse -> IDLE.
    - trigger with i_set_en=0 -> RINGING.
    - A trigger while i_set_en=1 is ignored.
  - RINGING:
    - arm pulse -> IDLE.
    - stop pulse -> ARMED.
    - timeout -> ARMED.
    - i_set_en=1 -> ARMED.
- Priority for same-cycle events: arm > stop > set_en > timeout > trigger.
- Latency: o_ringing rises on the 4th rising clk edge after i_sec/i_min settle to matching values (2 sync + match reg + state).
- Ring timer:
  - On entry to RINGING, prescaler p (0..CLK_HZ-1) and second counter rs (0..RING_SEC-1) clear to 0.
  - rs increments when p wraps.
  - Timeout occurs when p wraps with rs == RING_SEC-1, so the ring lasts exactly RING_SEC*CLK_HZ cycles.
  - p and rs hold at 0 outside RINGING.
- Buzzer:
  - Tone counter period is CLK_HZ/(2*TONE_HZ) cycles per toggle. It runs only in RINGING and starts low.
  - gate = (p < CLK_HZ/2).
  - o_buzz = RINGING AND gate AND tone, which gives 0.5 s beep / 0.5 s silence per second.
  - o_buzz is registered and is 0 in the same cycle the state leaves RINGING.
- Re-trigger: after stop or timeout, ringing requires match to drop and then re-assert. In practice this is the next hour cycle.

Test Plan:
Bench overrides: CLK_HZ=1000, TONE_HZ=100, RING_SEC=3.
1. Reset/setup:
   - After reset, all outputs are 0.
   - set_en=1, pos=1, 5 inc pulses; pos=0, 62 inc pulses -> o_alarm_min=5, o_alarm_sec=2 (wrap 59->0 seen, no carry to minutes).
2. Arm and ring:
   - Arm pulse -> o_armed=1.
   - Drive i_min=5, i_sec=2 -> o_ringing=1 exactly 4 clk edges later.
   - o_buzz toggles every 5 cycles during p<500 and is 0 during p>=500.
3. Timeout:
   - Hold the match -> o_ringing falls after exactly 3000 cycles; state is ARMED and there is no re-ring while the match persists.
   - Change i_sec to 3 and back to 2 -> rings again.
4. Stop vs disarm:
   - While ringing, stop pulse -> ARMED, o_buzz=0 next cycle.
   - Re-trigger, then arm pulse -> IDLE, o_armed=0.
   - Stop and arm rising together -> IDLE (arm wins).
5. Setup blocks ringing: i_set_en=1 during a match -> no ring. i_set_en rising during RINGING -> ARMED.
6. Async reset: assert rst_n low mid-ring, between clk edges -> o_ringing, o_buzz, o_armed and alarm fields are 0 immediately.
